fetch_control: RTL

//  Control partner of the instruction fetch stage: drives its pc_load, if_id_load, mux3_selector and pc_branch_in.

---
 rtl/fetch_control.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_control.sv
// Fetch-stage control: load-use stalls, EX redirects with IF/ID flush, and memory freezes.
// Optional perf counters (stall_cycles, flush_cycles) are built when FETCH_CTRL_PERF_EN is defined.
module fetch_control #(
    parameter int unsigned WIDTH_PC     = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FLUSH_CYCLES = 2
`ifdef FETCH_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W        = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic [WIDTH_PC-1:0]   ex_branch_target,
    input  logic                  mem_busy,
    output logic                  pc_load,
    output logic                  if_id_load,
    output logic                  mux3_selector,
    output logic [WIDTH_PC-1:0]   pc_branch_in,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
`endif
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StFlush     = 2'd2,
        StFreeze    = 2'd3
    } state_e;

    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

    state_e              state_q, state_d;
    logic [1:0]          flush_cnt_q, flush_cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic [WIDTH_PC-1:0] pend_target_q, pend_target_d;

    logic                hazard;
    logic                redirect;
    logic [WIDTH_PC-1:0] redirect_target;
    logic                pc_load_c, if_id_load_c, mux_c, flush_c, bubble_c;
    logic [WIDTH_PC-1:0] target_c;

    assign hazard = ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        pend_valid_d    = pend_valid_q;
        pend_target_d   = pend_target_q;
        pc_load_c       = 1'b1;
        if_id_load_c    = 1'b1;
        mux_c           = 1'b0;
        target_c        = '0;
        flush_c         = 1'b0;
        bubble_c        = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;

        if (mem_busy) begin
            // Freeze the front end; a branch resolved meanwhile is replayed on thaw.
            pc_load_c    = 1'b0;
            if_id_load_c = 1'b0;
            state_d      = StFreeze;
            flush_cnt_d  = '0;
            if (ex_branch_taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = ex_branch_target;
            end
        end else begin
            if (state_q == StFreeze && pend_valid_q) begin
                redirect        = 1'b1;
                redirect_target = pend_target_q;
                pend_valid_d    = 1'b0;
            end else if (ex_branch_taken) begin
                redirect        = 1'b1;
                redirect_target = ex_branch_target;
            end

            if (redirect) begin
                mux_c       = 1'b1;
                target_c    = redirect_target;
                flush_c     = 1'b1;
                bubble_c    = 1'b1;
                state_d     = (FLUSH_CYCLES > 1) ? StFlush : StRun;
                flush_cnt_d = (FLUSH_CYCLES > 1) ? FlushInit : 2'd0;
            end else if (hazard && state_q != StLoadStall) begin
                // flush_cnt deliberately holds here.
                pc_load_c    = 1'b0;
                if_id_load_c = 1'b0;
                bubble_c     = 1'b1;
                state_d      = StLoadStall;
            end else begin
                state_d     = StRun;
                flush_cnt_d = '0;
                if (state_q == StFlush) begin
                    flush_c = 1'b1;
                    if (flush_cnt_q > 2'd1) begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                        state_d     = StFlush;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            flush_cnt_q   <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // All outputs are forced low while reset is held.
    assign pc_load       = ~reset & pc_load_c;
    assign if_id_load    = ~reset & if_id_load_c;
    assign mux3_selector = ~reset & mux_c;
    assign if_id_flush   = ~reset & flush_c;
    assign id_ex_bubble  = ~reset & bubble_c;
    assign pc_branch_in  = reset ? '0 : target_c;

`ifdef FETCH_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, flushc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            flushc_q <= '0;
        end else begin
            if (!pc_load && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (if_id_flush && flushc_q != '1) begin
                flushc_q <= flushc_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flushc_q;
`endif

endmodule
